// File: rtl/grf_pkg.sv
// Shared types and widths for the GRF write-back path.
//   GRF_AW / GRF_DW : register address / data (and PC) widths
//   REG_ZERO        : hard-wired zero register; writes to it are dropped
//   wb_req_t        : one queued write-back request {wa, wd, pc}
package grf_pkg;

  localparam int unsigned GRF_AW = 5;
  localparam int unsigned GRF_DW = 32;

  localparam logic [GRF_AW-1:0] REG_ZERO = GRF_AW'(0);

  typedef struct packed {
    logic [GRF_AW-1:0] wa;
    logic [GRF_DW-1:0] wd;
    logic [GRF_DW-1:0] pc;
  } wb_req_t;

endpackage

// File: rtl/grf_wb_port_if.sv
// Bus bundle between the pipeline / long-latency unit and the GRF write port.
//   pipe_* : W-stage write request (in to the port)
//   lu_*   : long-latency result handshake (lu_ready flows back)
//   rwe/wa/wd/pc : GRF write port (out of the port)
// master = producers / GRF side stimulus, slave = grf_wb_port.
interface grf_wb_port_if
  import grf_pkg::*;
#(
  parameter int unsigned AW = GRF_AW,
  parameter int unsigned DW = GRF_DW
) ();

  logic          pipe_we;
  logic [AW-1:0] pipe_wa;
  logic [DW-1:0] pipe_wd;
  logic [DW-1:0] pipe_pc;

  logic          lu_valid;
  logic          lu_ready;
  logic [AW-1:0] lu_wa;
  logic [DW-1:0] lu_wd;
  logic [DW-1:0] lu_pc;

  logic          rwe;
  logic [AW-1:0] wa;
  logic [DW-1:0] wd;
  logic [DW-1:0] pc;

  modport master (
    output pipe_we, pipe_wa, pipe_wd, pipe_pc,
    output lu_valid, lu_wa, lu_wd, lu_pc,
    input  lu_ready,
    input  rwe, wa, wd, pc
  );

  modport slave (
    input  pipe_we, pipe_wa, pipe_wd, pipe_pc,
    input  lu_valid, lu_wa, lu_wd, lu_pc,
    output lu_ready,
    output rwe, wa, wd, pc
  );

endinterface

// File: rtl/grf_wb_fifo.sv
// Circular queue of late write-back requests with per-entry valid bits.
//   clk, Reset       : clock, synchronous active-high reset
//   push, push_req   : store a request at the tail (caller guarantees not full)
//   pop              : retire the head (caller guarantees not empty)
//   squash_en/_wa    : invalidate every stored entry targeting squash_wa
//   head_req/_valid  : current head entry and its valid bit
//   count            : occupied entries, squashed ones included
//   busy_mask        : bit i set while a valid entry targets register i
module grf_wb_fifo
  import grf_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic                           clk,
  input  logic                           Reset,
  input  logic                           push,
  input  wb_req_t                        push_req,
  input  logic                           pop,
  input  logic                           squash_en,
  input  logic [GRF_AW-1:0]              squash_wa,
  output wb_req_t                        head_req,
  output logic                           head_valid,
  output logic [$clog2(DEPTH+1)-1:0]     count,
  output logic [(2**GRF_AW)-1:0]         busy_mask
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = $clog2(DEPTH+1);

  wb_req_t          mem [DEPTH];
  logic [DEPTH-1:0] vld;
  logic [PW-1:0]    rd_ptr;
  logic [PW-1:0]    wr_ptr;

  // Squash only touches entries already stored; a same-cycle push is younger and stays valid.
  always_ff @(posedge clk) begin
    if (Reset) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
      vld    <= '0;
    end else begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        if (squash_en && vld[i] && (mem[i].wa == squash_wa)) vld[i] <= 1'b0;
      end
      if (pop) begin
        vld[rd_ptr] <= 1'b0;
        rd_ptr      <= PW'(rd_ptr + 1'b1);
      end
      if (push) begin
        mem[wr_ptr] <= push_req;
        vld[wr_ptr] <= 1'b1;
        wr_ptr      <= PW'(wr_ptr + 1'b1);
      end
      count <= CW'(count + CW'(push) - CW'(pop));
    end
  end

  assign head_req   = mem[rd_ptr];
  assign head_valid = vld[rd_ptr];

  // Valid bits are cleared on pop, so vld alone marks pending writes.
  always_comb begin
    busy_mask = '0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      if (vld[i]) busy_mask[mem[i].wa] = 1'b1;
    end
    busy_mask[0] = 1'b0;
  end

endmodule

// File: rtl/grf_wb_port.sv
// GRF write-port arbiter: W-stage writes win; LU results queue and drain on idle port cycles.
//   clk, Reset : clock, synchronous active-high reset
//   bus        : grf_wb_port_if.slave (pipe_*, lu_* handshake, rwe/wa/wd/pc)
//   busy_mask  : per-register pending-queued-write flags for the hazard unit
//   q_count    : occupied queue entries (squashed included)
// Optional: define GRF_TRACE_EN to print a commit/squash trace at each clock edge.
module grf_wb_port
  import grf_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic                         clk,
  input  logic                         Reset,
  grf_wb_port_if.slave                 bus,
  output logic [(2**GRF_AW)-1:0]       busy_mask,
  output logic [$clog2(DEPTH+1)-1:0]   q_count
);

  localparam int unsigned CW = $clog2(DEPTH+1);

  logic                    pipe_hit;
  logic                    q_nonempty;
  logic                    pop;
  logic                    push;
  wb_req_t                 head_req;
  logic                    head_valid;
  logic [(2**GRF_AW)-1:0]  fifo_busy;

  assign pipe_hit   = bus.pipe_we && (bus.pipe_wa != REG_ZERO);
  assign q_nonempty = (q_count != '0);
  assign pop        = !Reset && !pipe_hit && q_nonempty;

  // Ready depends on registered occupancy only: no pop-through when full.
  assign bus.lu_ready = !Reset && (q_count < CW'(DEPTH));
  // $0 results complete the handshake but are dropped.
  assign push         = bus.lu_valid && bus.lu_ready && (bus.lu_wa != REG_ZERO);
  assign busy_mask    = Reset ? '0 : fifo_busy;

  grf_wb_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk        (clk),
    .Reset      (Reset),
    .push       (push),
    .push_req   ('{wa: bus.lu_wa, wd: bus.lu_wd, pc: bus.lu_pc}),
    .pop        (pop),
    .squash_en  (pipe_hit),
    .squash_wa  (bus.pipe_wa),
    .head_req   (head_req),
    .head_valid (head_valid),
    .count      (q_count),
    .busy_mask  (fifo_busy)
  );

  // Write-port priority mux; a squashed head still spends its pop cycle with rwe low.
  always_comb begin
    bus.rwe = 1'b0;
    bus.wa  = '0;
    bus.wd  = '0;
    bus.pc  = '0;
    if (!Reset) begin
      if (pipe_hit) begin
        bus.rwe = 1'b1;
        bus.wa  = bus.pipe_wa;
        bus.wd  = bus.pipe_wd;
        bus.pc  = bus.pipe_pc;
      end else if (q_nonempty) begin
        bus.rwe = head_valid;
        bus.wa  = head_req.wa;
        bus.wd  = head_req.wd;
        bus.pc  = head_req.pc;
      end
    end
  end

`ifdef GRF_TRACE_EN
  always_ff @(posedge clk) begin
    if (!Reset) begin
      if (bus.rwe) $display("%d@%h: $%d <= %h", $time, bus.pc, bus.wa, bus.wd);
      else if (pop && !head_valid) $display("%d: squash $%d", $time, head_req.wa);
    end
  end
`endif

endmodule
